// File: rtl/alu_issue.sv
// Purpose: MIPS issue stage; decodes opcode/funct to ALU ctl and registers ctl/a/b behind a 2-entry skid buffer.
// Latency: 1 cycle from input accept to ctl/a/b; outputs come straight from flops.
// Backpressure: in_ready = !skid_full & !flush; ctl/a/b hold while out_valid & !out_ready. Optional: ALU_ISSUE_ILLEGAL_EN adds 'illegal'.
module alu_issue #(
    parameter int          DATA_W   = 32,
    parameter logic [3:0]  IDLE_CTL = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [15:0]       imm16,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        ctl,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic              illegal
`endif
);

    typedef struct packed {
        logic [3:0]        ctl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
`ifdef ALU_ISSUE_ILLEGAL_EN
        logic              ill;
`endif
    } entry_t;

    entry_t            main_dat;
    entry_t            skid_dat;
    entry_t            dec_dat;
    logic              main_vld;
    logic              skid_vld;
    logic              live;
    logic              known;
    logic              in_fire;
    logic              out_fire;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;

    assign imm_sext = {{(DATA_W-16){imm16[15]}}, imm16};
    assign imm_zext = {{(DATA_W-16){1'b0}}, imm16};

    // in_ready stays low until the first clock edge after reset release.
    assign in_ready  = live & ~skid_vld & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_vld & out_ready;

    assign out_valid = main_vld;
    assign ctl       = main_dat.ctl;
    assign a         = main_dat.a;
    assign b         = main_dat.b;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign illegal   = main_dat.ill;
`endif

    // Decode opcode/funct into ALU control and select operand B.
    always_comb begin
        dec_dat     = '0;
        dec_dat.a   = rs_val;
        dec_dat.b   = rt_val;
        dec_dat.ctl = 4'b1111;
        known       = 1'b1;
        if (opcode == 6'b000000) begin
            case (funct)
                6'b100000, 6'b100001: dec_dat.ctl = 4'b0010;
                6'b100010, 6'b100011: dec_dat.ctl = 4'b0110;
                6'b100100:            dec_dat.ctl = 4'b0000;
                6'b100101:            dec_dat.ctl = 4'b0001;
                6'b100110:            dec_dat.ctl = 4'b1101;
                6'b100111:            dec_dat.ctl = 4'b1100;
                6'b101010:            dec_dat.ctl = 4'b0111;
                default:              known       = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
                    dec_dat.ctl = 4'b0010;
                    dec_dat.b   = imm_sext;
                end
                6'b001010: begin
                    dec_dat.ctl = 4'b0111;
                    dec_dat.b   = imm_sext;
                end
                6'b001100: begin
                    dec_dat.ctl = 4'b0000;
                    dec_dat.b   = imm_zext;
                end
                6'b001101: begin
                    dec_dat.ctl = 4'b0001;
                    dec_dat.b   = imm_zext;
                end
                6'b001110: begin
                    dec_dat.ctl = 4'b1101;
                    dec_dat.b   = imm_zext;
                end
                // Branches subtract rs-rt so the ALU zero flag resolves them.
                6'b000100, 6'b000101: dec_dat.ctl = 4'b0110;
                default:              known       = 1'b0;
            endcase
        end
        // Undecodable instructions issue as ctl=1111 with rs/rt operands.
        if (!known) begin
            dec_dat.ctl = 4'b1111;
            dec_dat.b   = rt_val;
        end
`ifdef ALU_ISSUE_ILLEGAL_EN
        dec_dat.ill = ~known;
`endif
    end

    // Marks the first edge after reset release so in_ready can rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Main/skid registers: FIFO order, flush wins, idle ctl whenever main is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld     <= 1'b0;
            skid_vld     <= 1'b0;
            main_dat     <= '0;
            main_dat.ctl <= IDLE_CTL;
            skid_dat     <= '0;
        end else if (flush) begin
            main_vld     <= 1'b0;
            skid_vld     <= 1'b0;
            main_dat     <= '0;
            main_dat.ctl <= IDLE_CTL;
        end else if (!main_vld) begin
            if (in_fire) begin
                main_vld <= 1'b1;
                main_dat <= dec_dat;
            end
        end else if (out_fire) begin
            if (skid_vld) begin
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else if (in_fire) begin
                main_dat <= dec_dat;
            end else begin
                main_vld     <= 1'b0;
                main_dat     <= '0;
                main_dat.ctl <= IDLE_CTL;
            end
        end else if (in_fire) begin
            skid_vld <= 1'b1;
            skid_dat <= dec_dat;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Purpose: randomized + directed bench for alu_issue with a queue scoreboard and behavioural decode model.
// Latency: expects each accepted instruction at the head of the output one edge later.
// Backpressure: models a 2-deep FIFO with flush clearing it and in_ready = room & !flush.
module tb_alu_issue;

    localparam logic [3:0] IDLE_CTL = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm16;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        illegal;
`endif

    alu_issue #(.DATA_W(32), .IDLE_CTL(IDLE_CTL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctl(ctl), .a(a), .b(b)
`ifdef ALU_ISSUE_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    logic live;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference decode: classify the instruction, then derive ctl and operand B.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm);
        exp_t e;
        logic [31:0] sx;
        logic [31:0] zx;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0000, imm};
        e.a = rs; e.b = rt; e.ctl = 4'hF; e.ill = 1'b1;
        if (op == 6'h00) begin
            e.ill = 1'b0;
            if (fn == 6'h20 || fn == 6'h21)      e.ctl = 4'h2;
            else if (fn == 6'h22 || fn == 6'h23) e.ctl = 4'h6;
            else if (fn == 6'h24)                e.ctl = 4'h0;
            else if (fn == 6'h25)                e.ctl = 4'h1;
            else if (fn == 6'h26)                e.ctl = 4'hD;
            else if (fn == 6'h27)                e.ctl = 4'hC;
            else if (fn == 6'h2A)                e.ctl = 4'h7;
            else                                 e.ill = 1'b1;
        end else if (op == 6'h08 || op == 6'h09 || op == 6'h23 || op == 6'h2B) begin
            e.ctl = 4'h2; e.b = sx; e.ill = 1'b0;
        end else if (op == 6'h0A) begin
            e.ctl = 4'h7; e.b = sx; e.ill = 1'b0;
        end else if (op == 6'h0C) begin
            e.ctl = 4'h0; e.b = zx; e.ill = 1'b0;
        end else if (op == 6'h0D) begin
            e.ctl = 4'h1; e.b = zx; e.ill = 1'b0;
        end else if (op == 6'h0E) begin
            e.ctl = 4'hD; e.b = zx; e.ill = 1'b0;
        end else if (op == 6'h04 || op == 6'h05) begin
            e.ctl = 4'h6; e.ill = 1'b0;
        end
        if (e.ill) begin
            e.ctl = 4'hF; e.b = rt;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    // Monitor: compare presented outputs to the scoreboard head, then apply this cycle's transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, live && q.size() < 2 && !flush});
            if (out_valid && q.size() > 0) begin
                chk("ctl", {28'd0, ctl}, {28'd0, q[0].ctl});
                chk("a", a, q[0].a);
                chk("b", b, q[0].b);
`ifdef ALU_ISSUE_ILLEGAL_EN
                chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
`endif
            end else if (!out_valid) begin
                chk("idle_ctl", {28'd0, ctl}, {28'd0, IDLE_CTL});
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && in_ready) q.push_back(model(opcode, funct, rs_val, rt_val, imm16));
            end
        end
    end

    // Present one instruction and hold it until accepted (bounded).
    task automatic send(input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; opcode = op; funct = fn; rs_val = rs; rt_val = rt; imm16 = imm;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Send with out_ready=1 on an empty stage, then check the next-cycle outputs against constants.
    task automatic send_check(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                              input logic [3:0] ectl, input logic [31:0] ea, input logic [31:0] eb);
        out_ready = 1'b1;
        send(op, fn, rs, rt, imm);
        @(negedge clk);
        chk({name, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_ctl"}, {28'd0, ctl}, {28'd0, ectl});
        chk({name, "_a"}, a, ea);
        chk({name, "_b"}, b, eb);
        @(posedge clk); #1;
    endtask

    logic [5:0] op_tab [0:15];
    logic [5:0] fn_tab [0:9];

    initial begin
        int acc_cnt;
        op_tab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C,
                   6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F, 6'h02};
        fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctl", {28'd0, ctl}, {28'd0, IDLE_CTL});
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Directed decode cases
        send_check("add",   6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 4'h2, 32'd5, 32'd7);
        send_check("addi",  6'h08, 6'h00, 32'd3, 32'd1, 16'hFFFF, 4'h2, 32'd3, 32'hFFFFFFFF);
        send_check("ori",   6'h0D, 6'h00, 32'd3, 32'd1, 16'hFFFF, 4'h1, 32'd3, 32'h0000FFFF);
        send_check("beq",   6'h04, 6'h00, 32'd9, 32'd9, 16'h0010, 4'h6, 32'd9, 32'd9);
        send_check("slti",  6'h0A, 6'h00, 32'hFFFFFFFF, 32'd4, 16'h0000, 4'h7, 32'hFFFFFFFF, 32'd0);
        send_check("ill",   6'h3F, 6'h00, 32'd11, 32'd12, 16'h1234, 4'hF, 32'd11, 32'd12);
`ifdef ALU_ISSUE_ILLEGAL_EN
        // illegal was sampled one cycle ago; re-send to observe it directly
        out_ready = 1'b0;
        send(6'h3F, 6'h00, 32'd1, 32'd2, 16'h0);
        @(negedge clk);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
`endif

        // Backpressure: hold in_valid with out_ready=0, only two accepts fit
        out_ready = 1'b0;
        acc_cnt = 0;
        in_valid = 1'b1; opcode = 6'h00; funct = 6'h22; rt_val = 32'd1; imm16 = '0;
        for (int i = 0; i < 4; i++) begin
            rs_val = 32'd100 + i;
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
            @(posedge clk); #1;
        end
        chk("bp_accepts", acc_cnt, 32'd2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Flush with both entries full and an input pending
        out_ready = 1'b0;
        send(6'h00, 6'h24, 32'd1, 32'd2, 16'h0);
        send(6'h00, 6'h25, 32'd3, 32'd4, 16'h0);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            opcode    = op_tab[$urandom_range(0, 15)];
            funct     = fn_tab[$urandom_range(0, 9)];
            rs_val    = $urandom;
            rt_val    = $urandom;
            imm16     = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0;

        // Asynchronous reset mid-stream with an undecodable instruction in flight
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(6'h3F, 6'h00, 32'd7, 32'd8, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ctl", {28'd0, ctl}, {28'd0, IDLE_CTL});
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("arst_illegal", {31'd0, illegal}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_check("post_rst", 6'h00, 6'h27, 32'hF0F0F0F0, 32'h0F0F0F0F, 16'h0, 4'hC,
                   32'hF0F0F0F0, 32'h0F0F0F0F);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Issue stage that drives the 32-bit ALU's ctl/a/b operand interface. Decodes MIPS opcode/funct into the 4-bit ALU control code, selects operand B (rt or extended imm16) and presents registered operands through a valid/ready handshake. Contains a 2-entry skid buffer so upstream decode and the execute stage can stall independently. Sits between register-file read and the ALU.

Parameters:
DATA_W, 32, operand width; only 32 is supported.
IDLE_CTL, 4'b0000, ctl value driven while out_valid=0.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept this cycle
opcode  input  6  instr[31:26]
funct  input  6  instr[5:0]
rs_val  input  DATA_W  register rs value
rt_val  input  DATA_W  register rt value
imm16  input  16  instr[15:0]
out_valid  output  1  ctl/a/b valid toward ALU
out_ready  input  1  execute stage accepts
ctl  output  4  ALU control code
a  output  DATA_W  ALU operand A
b  output  DATA_W  ALU operand B

Behaviour:
- Clock and reset: one clock, clk; reset is rst_n, asynchronous and active-low.
- Reset: out_valid=0, ctl=IDLE_CTL, a=0, b=0, both skid entries empty. in_ready=1 from the first clk edge after deassert.
- Transfers: in on in_valid&in_ready; out on out_valid&out_ready.
- Latency: an accepted instruction appears on ctl/a/b at the next rising edge. Outputs come straight from flops.
- Buffer: main register plus one skid register. in_ready = !skid_full & !flush. Skid is filled when main is valid, out_ready=0 and an input is accepted.
- Ordering: strictly FIFO. On an out transfer, skid moves to main.
- Simultaneous in and out transfer with skid empty: the new instruction replaces main, no bubble.
- Stability: while out_valid=1 and out_ready=0, ctl/a/b hold stable.
- R-type (opcode 000000): a=rs_val, b=rt_val.
  - ctl by funct: 100000/100001 add/addu -> 0010; 100010/100011 sub/subu -> 0110; 100100 and -> 0000; 100101 or -> 0001; 100110 xor -> 1101; 100111 nor -> 1100; 101010 slt -> 0111.
- I-type: a=rs_val.
  - Sign-extended imm16: addi 001000 and addiu 001001 -> 0010; slti 001010 -> 0111; lw 100011 and sw 101011 -> 0010.
  - Zero-extended imm16: andi 001100 -> 0000; ori 001101 -> 0001; xori 001110 -> 1101.
  - beq 000100 and bne 000101: b=rt_val, ctl=0110, so the ALU's zero flag resolves the branch.
- Any other opcode/funct: ctl=1111 (ALU outputs 0), a=rs_val, b=rt_val.
- flush=1: both entries are invalidated at the edge and out_valid=0 next cycle. in_ready=0 during flush, so no input is accepted. Flush has priority over every transfer.
- Reset asserted mid-operation: all state clears immediately; buffered instructions are lost.

Optional Feature:
ALU_ISSUE_ILLEGAL_EN
- Defined: adds output port illegal (1 bit), registered and buffered with its instruction. It is 1 for undecodable opcode/funct, ctl is still 1111, and it resets to 0.
- Undefined: no illegal port; undecodable instructions are issued silently with ctl=1111.

Test Plan:
- Reset then add: rs=5, rt=7, funct 100000, out_ready=1 -> next cycle out_valid=1, ctl=0010, a=5, b=7.
- Immediate extension: addi imm16=16'hFFFF -> b=32'hFFFFFFFF, ctl=0010. ori imm16=16'hFFFF -> b=32'h0000FFFF, ctl=0001.
- Backpressure: 3 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepts. Release out_ready -> outputs appear in order, none lost or duplicated, ctl/a/b stable while stalled.
- Branch: beq rs=9, rt=9 -> ctl=0110, b=9 (ALU z=1). slti rs=-1, imm=0 -> ctl=0111, b=0.
- Flush with both entries full and in_valid=1 -> out_valid=0 next cycle, input not accepted, in_ready=1 the cycle after.
- Illegal: opcode 111111 -> ctl=1111. With ALU_ISSUE_ILLEGAL_EN, illegal=1; mid-stream rst_n=0 -> out_valid=0, illegal=0 asynchronously.
